// File: rtl/usb2_pkg.sv
// Shared definitions for the USB 2.0 bulk IN packer slice.
// Contents:
//   packer_state_e    - packer FSM state encoding
//   USB2_HS_BULK_MAX  - high-speed bulk max packet size (bytes)
//   BUF_ADDR_W        - endpoint buffer address width
//   BUF_LEN_W         - committed packet length width
package usb2_pkg;

  localparam int USB2_HS_BULK_MAX = 512;
  localparam int BUF_ADDR_W       = 9;
  localparam int BUF_LEN_W        = 10;

  typedef enum logic [1:0] {
    WAIT_BUF     = 2'd0,
    FILL         = 2'd1,
    COMMIT       = 2'd2,
    WAIT_ACK_LOW = 2'd3
  } packer_state_e;

endpackage

// File: rtl/usb2_sync2.sv
// Two-flop synchroniser for a single level signal into the clk domain.
// Ports:
//   clk   in  - destination clock
//   rst_n in  - asynchronous active-low reset (output resets to 0)
//   d     in  - asynchronous level input
//   q     out - synchronised level, two clk cycles of latency
module usb2_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture chain; first stage may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/usb2_bulk_in_packer.sv
// Packs a valid/ready byte stream into USB 2.0 IN endpoint-buffer writes,
// commits each packet with its length and waits for the commit handshake
// and a free buffer before filling the next one.
// Optional build macro: USB2_PACKER_TIMEOUT_EN - flushes a partial packet
// after TIMEOUT_CYC idle cycles in FILL.
// Ports:
//   ext_clk, reset_n                 - clock, async active-low reset
//   s_data/s_valid/s_last/s_ready    - input byte stream
//   buf_in_addr/data/wren            - endpoint buffer write port
//   buf_in_ready                     - buffer free (async, synchronised)
//   buf_in_commit/_len/_ack          - packet commit handshake (ack synchronised)
//   stat_pkt_count, stat_busy        - status
module usb2_bulk_in_packer
  import usb2_pkg::*;
#(
  parameter int MAX_PKT     = USB2_HS_BULK_MAX,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  ext_clk,
  input  logic                  reset_n,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [BUF_ADDR_W-1:0] buf_in_addr,
  output logic [7:0]            buf_in_data,
  output logic                  buf_in_wren,
  input  logic                  buf_in_ready,
  output logic                  buf_in_commit,
  output logic [BUF_LEN_W-1:0]  buf_in_commit_len,
  input  logic                  buf_in_commit_ack,
  output logic [15:0]           stat_pkt_count,
  output logic                  stat_busy
);

  localparam logic [BUF_LEN_W-1:0] MAX_LEN = BUF_LEN_W'(MAX_PKT);

  packer_state_e         state_r, state_n;
  logic [BUF_LEN_W-1:0]  count_r, count_n;
  logic                  s_ready_r, s_ready_n;
  logic [BUF_ADDR_W-1:0] addr_r, addr_n;
  logic [7:0]            data_r, data_n;
  logic                  wren_r, wren_n;
  logic                  commit_r, commit_n;
  logic [BUF_LEN_W-1:0]  len_r, len_n;
  logic [15:0]           pkt_r, pkt_n;
  logic                  busy_r, busy_n;
  logic                  ready_sync;
  logic                  ack_sync;
  logic                  accept;

`ifdef USB2_PACKER_TIMEOUT_EN
  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT_CYC - 1);
  logic [15:0] idle_r, idle_n;
`endif

  usb2_sync2 u_sync_ready (
    .clk   (ext_clk),
    .rst_n (reset_n),
    .d     (buf_in_ready),
    .q     (ready_sync)
  );

  usb2_sync2 u_sync_ack (
    .clk   (ext_clk),
    .rst_n (reset_n),
    .d     (buf_in_commit_ack),
    .q     (ack_sync)
  );

  // s_ready is registered, so a byte is taken exactly when the upstream sees it high.
  assign accept = s_valid & s_ready_r;

  // Next-state and next-output computation for the packer FSM.
  always_comb begin
    state_n   = state_r;
    count_n   = count_r;
    s_ready_n = 1'b0;
    wren_n    = 1'b0;
    addr_n    = addr_r;
    data_n    = data_r;
    commit_n  = 1'b0;
    len_n     = len_r;
    pkt_n     = pkt_r;
`ifdef USB2_PACKER_TIMEOUT_EN
    idle_n    = 16'd0;
`endif
    case (state_r)
      WAIT_BUF: begin
        if (ready_sync && !ack_sync) begin
          state_n   = FILL;
          s_ready_n = 1'b1;
        end else begin
          state_n = WAIT_BUF;
        end
      end
      FILL: begin
        s_ready_n = 1'b1;
        if (accept) begin
          wren_n  = 1'b1;
          addr_n  = count_r[BUF_ADDR_W-1:0];
          data_n  = s_data;
          count_n = count_r + 10'd1;
          // Drop s_ready on the same edge so nothing lands after the final byte.
          if ((count_r + 10'd1 == MAX_LEN) || s_last) begin
            state_n   = COMMIT;
            s_ready_n = 1'b0;
          end else begin
            state_n = FILL;
          end
        end else begin
`ifdef USB2_PACKER_TIMEOUT_EN
          if (count_r != 10'd0) begin
            if (idle_r == IDLE_LIMIT) begin
              state_n   = COMMIT;
              s_ready_n = 1'b0;
              idle_n    = 16'd0;
            end else begin
              idle_n = idle_r + 16'd1;
            end
          end else begin
            idle_n = 16'd0;
          end
`else
          state_n = FILL;
`endif
        end
      end
      COMMIT: begin
        commit_n = 1'b1;
        len_n    = count_r;
        // Only honour ack once our own request is visible on the port.
        if (commit_r && ack_sync) begin
          commit_n = 1'b0;
          count_n  = 10'd0;
          pkt_n    = pkt_r + 16'd1;
          state_n  = WAIT_ACK_LOW;
        end else begin
          state_n = COMMIT;
        end
      end
      WAIT_ACK_LOW: begin
        if (!ack_sync) begin
          state_n = WAIT_BUF;
        end else begin
          state_n = WAIT_ACK_LOW;
        end
      end
      default: begin
        state_n = WAIT_BUF;
        count_n = 10'd0;
      end
    endcase
    busy_n = !((state_n == WAIT_BUF) && (count_n == 10'd0));
  end

  // FSM state, byte count and registered outputs.
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= WAIT_BUF;
      count_r   <= 10'd0;
      s_ready_r <= 1'b0;
      addr_r    <= 9'd0;
      data_r    <= 8'd0;
      wren_r    <= 1'b0;
      commit_r  <= 1'b0;
      len_r     <= 10'd0;
      pkt_r     <= 16'd0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      count_r   <= count_n;
      s_ready_r <= s_ready_n;
      addr_r    <= addr_n;
      data_r    <= data_n;
      wren_r    <= wren_n;
      commit_r  <= commit_n;
      len_r     <= len_n;
      pkt_r     <= pkt_n;
      busy_r    <= busy_n;
    end
  end

`ifdef USB2_PACKER_TIMEOUT_EN
  // Idle-cycle counter for flushing a stalled partial packet.
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_r <= 16'd0;
    end else begin
      idle_r <= idle_n;
    end
  end
`endif

  assign s_ready           = s_ready_r;
  assign buf_in_addr       = addr_r;
  assign buf_in_data       = data_r;
  assign buf_in_wren       = wren_r;
  assign buf_in_commit     = commit_r;
  assign buf_in_commit_len = len_r;
  assign stat_pkt_count    = pkt_r;
  assign stat_busy         = busy_r;

endmodule

// File: tb/tb_usb2_bulk_in_packer.sv
// Directed self-checking bench for usb2_bulk_in_packer.
// Build with USB2_PACKER_TIMEOUT_EN defined to exercise the idle flush.
module tb_usb2_bulk_in_packer;

  localparam int TIMEOUT_CYC = 16;

  logic       ext_clk = 1'b0;
  logic       reset_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [8:0] buf_in_addr;
  logic [7:0] buf_in_data;
  logic       buf_in_wren;
  logic       buf_in_ready;
  logic       buf_in_commit;
  logic [9:0] buf_in_commit_len;
  logic       buf_in_commit_ack = 1'b0;
  logic [15:0] stat_pkt_count;
  logic       stat_busy;

  int total = 0;
  int bad   = 0;
  int to_err = 0;

  // monitor state
  logic [8:0] wr_addr[$];
  logic [7:0] wr_data[$];
  int         commit_lens[$];
  int         cyc = 0;
  int         last_wren_cyc = 0;
  int         commit_rise_cyc = 0;
  int         len_err = 0;
  logic       commit_prev = 1'b0;
  logic [9:0] len_held = 10'd0;
  int         ack_cnt = 0;

  usb2_bulk_in_packer #(
    .MAX_PKT     (512),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .ext_clk           (ext_clk),
    .reset_n           (reset_n),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_last            (s_last),
    .s_ready           (s_ready),
    .buf_in_addr       (buf_in_addr),
    .buf_in_data       (buf_in_data),
    .buf_in_wren       (buf_in_wren),
    .buf_in_ready      (buf_in_ready),
    .buf_in_commit     (buf_in_commit),
    .buf_in_commit_len (buf_in_commit_len),
    .buf_in_commit_ack (buf_in_commit_ack),
    .stat_pkt_count    (stat_pkt_count),
    .stat_busy         (stat_busy)
  );

  always #5 ext_clk = ~ext_clk;

  // Record buffer writes and commits, away from the active edge.
  always @(negedge ext_clk) begin
    cyc++;
    if (buf_in_wren) begin
      wr_addr.push_back(buf_in_addr);
      wr_data.push_back(buf_in_data);
      last_wren_cyc = cyc;
    end
    if (buf_in_commit && !commit_prev) begin
      commit_lens.push_back(int'(buf_in_commit_len));
      commit_rise_cyc = cyc;
      len_held = buf_in_commit_len;
    end else if (buf_in_commit && (buf_in_commit_len !== len_held)) begin
      len_err++;
    end
    commit_prev = buf_in_commit;
  end

  // Host side of the commit handshake: ack 4 cycles after commit, drop after commit falls.
  always @(negedge ext_clk) begin
    if (buf_in_commit && !buf_in_commit_ack) begin
      ack_cnt++;
      if (ack_cnt >= 4) buf_in_commit_ack = 1'b1;
    end else if (!buf_in_commit && buf_in_commit_ack) begin
      buf_in_commit_ack = 1'b0;
      ack_cnt = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one byte from a negedge and return at the negedge after it is taken.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = l;
    while (!s_ready && n < 50) begin
      @(negedge ext_clk);
      n++;
    end
    if (s_ready) @(negedge ext_clk);
    else to_err++;
  endtask

  task automatic idle_stream();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    commit_lens.delete();
  endtask

  task automatic wait_pkt(input string tag, input int target);
    int n = 0;
    while (int'(stat_pkt_count) != target && n < 2000) begin
      @(negedge ext_clk);
      n++;
    end
    check_eq(tag, stat_pkt_count, target);
  endtask

  task automatic check_writes(input string tag, input logic [7:0] exp_d[$]);
    int errs = 0;
    check_eq({tag, "_wr_count"}, wr_addr.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < wr_addr.size(); i++) begin
      if (wr_addr[i] !== 9'(i) || wr_data[i] !== exp_d[i]) errs++;
    end
    check_eq({tag, "_wr_content"}, errs, 0);
  endtask

  task automatic check_one_commit(input string tag, input int len);
    check_eq({tag, "_commits"}, commit_lens.size(), 1);
    check_eq({tag, "_len"}, (commit_lens.size() > 0) ? commit_lens[0] : -1, len);
  endtask

  initial begin
    logic [7:0] exp_d[$];
    int n;

    reset_n = 1'b0;
    s_data = 8'd0;
    s_valid = 1'b0;
    s_last = 1'b0;
    buf_in_ready = 1'b0;
    repeat (3) @(negedge ext_clk);
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_wren", buf_in_wren, 0);
    check_eq("rst_commit", buf_in_commit, 0);
    check_eq("rst_len", buf_in_commit_len, 0);
    check_eq("rst_pkt", stat_pkt_count, 0);
    check_eq("rst_busy", stat_busy, 0);
    reset_n = 1'b1;

    // Backpressure: buffer not ready, upstream valid.
    s_data = 8'h00;
    s_valid = 1'b1;
    repeat (10) @(negedge ext_clk);
    check_eq("bp_s_ready", s_ready, 0);
    check_eq("bp_no_wren", wr_addr.size(), 0);
    check_eq("bp_busy", stat_busy, 0);
    buf_in_ready = 1'b1;
    n = 0;
    while (!s_ready && n < 10) begin
      @(negedge ext_clk);
      n++;
    end
    // 2 sync flops + 1 registered transition; accept on the following edge (4th).
    check_eq("bp_latency", n, 3);

    // Full packet of 512 back-to-back bytes.
    exp_d.delete();
    for (int i = 0; i < 512; i++) begin
      send_byte(8'(i), 1'b0);
      exp_d.push_back(8'(i));
    end
    idle_stream();
    check_eq("full_s_ready_drop", s_ready, 0);
    check_eq("full_busy", stat_busy, 1);
    n = 0;
    while (!s_ready && n < 200) begin
      @(negedge ext_clk);
      n++;
    end
    check_eq("full_reopen", s_ready, 1);
    check_eq("full_reopen_ack_low", buf_in_commit_ack, 0);
    check_eq("full_pkt", stat_pkt_count, 1);
    check_writes("full", exp_d);
    check_one_commit("full", 512);
    check_eq("full_commit_delay", commit_rise_cyc - last_wren_cyc, 1);

    // Short packet with s_last on the third byte.
    clear_mon();
    exp_d = '{8'hA1, 8'hA2, 8'hA3};
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b1);
    idle_stream();
    wait_pkt("short_pkt", 2);
    repeat (10) @(negedge ext_clk);
    check_writes("short", exp_d);
    check_one_commit("short", 3);
    check_eq("short_commit_delay", commit_rise_cyc - last_wren_cyc, 1);

    // s_last on the 512th byte: single commit, no zero-length packet.
    clear_mon();
    exp_d.delete();
    for (int i = 0; i < 512; i++) begin
      send_byte(8'(i) ^ 8'h5A, (i == 511));
      exp_d.push_back(8'(i) ^ 8'h5A);
    end
    idle_stream();
    wait_pkt("last512_pkt", 3);
    repeat (20) @(negedge ext_clk);
    check_writes("last512", exp_d);
    check_one_commit("last512", 512);

    // s_last on the first byte.
    clear_mon();
    exp_d = '{8'h3C};
    send_byte(8'h3C, 1'b1);
    idle_stream();
    wait_pkt("first_pkt", 4);
    repeat (5) @(negedge ext_clk);
    check_writes("first", exp_d);
    check_one_commit("first", 1);

    // Reset in the middle of a packet.
    clear_mon();
    for (int i = 0; i < 100; i++) send_byte(8'(i + 1), 1'b0);
    idle_stream();
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_s_ready", s_ready, 0);
    check_eq("mid_rst_addr", buf_in_addr, 0);
    check_eq("mid_rst_data", buf_in_data, 0);
    check_eq("mid_rst_len", buf_in_commit_len, 0);
    check_eq("mid_rst_pkt", stat_pkt_count, 0);
    check_eq("mid_rst_busy", stat_busy, 0);
    @(negedge ext_clk);
    reset_n = 1'b1;
    check_eq("mid_rst_no_commit", commit_lens.size(), 0);
    clear_mon();
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), (i == 4));
    idle_stream();
    wait_pkt("after_rst_pkt", 1);
    repeat (5) @(negedge ext_clk);
    check_writes("after_rst", exp_d);
    check_one_commit("after_rst", 5);

    // Partial packet followed by idle.
    clear_mon();
    for (int i = 0; i < 7; i++) send_byte(8'hC0 + 8'(i), 1'b0);
    idle_stream();
`ifdef USB2_PACKER_TIMEOUT_EN
    wait_pkt("timeout_pkt", 2);
    check_one_commit("timeout", 7);
    // 16 idle edges reach the limit, commit appears on the following edge.
    check_eq("timeout_delay", commit_rise_cyc - last_wren_cyc, TIMEOUT_CYC + 1);
`else
    repeat (1000) @(negedge ext_clk);
    check_eq("no_timeout_commits", commit_lens.size(), 0);
    check_eq("no_timeout_busy", stat_busy, 1);
    check_eq("no_timeout_s_ready", s_ready, 1);
`endif

    check_eq("len_stable", len_err, 0);
    check_eq("accept_timeouts", to_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
